// File: rtl/gol_gen_ctrl.sv
// Game of Life (B3/S23) generation sequencer: one cell per clock into a shadow buffer, whole-grid commit.
// Optional macro GOL_WRAP_EN selects a toroidal grid; otherwise cells beyond the border count as dead.
module gol_gen_ctrl #(
   parameter int COLS  = 64,
   parameter int ROWS  = 48,
   parameter int GEN_W = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   run,
   input  logic                   tick,
   input  logic                   step,
   input  logic                   clear,
   input  logic                   load,
   input  logic [0:COLS*ROWS-1]   seed,
   output logic [0:COLS*ROWS-1]   cells,
   output logic                   busy,
   output logic                   done,
   output logic [GEN_W-1:0]       gen_count
);

   // state   | meaning
   // IDLE    | waiting for clear / load / step / run&&tick
   // COMPUTE | evaluating cell idx into the shadow buffer, one per clock
   // COMMIT  | copying the shadow buffer into cells, bumping gen_count
   localparam int N  = COLS * ROWS;
   localparam int IW = $clog2(N);

   typedef enum logic [1:0] {IDLE, COMPUTE, COMMIT} state_t;

   state_t          state, state_nx;
   logic [IW-1:0]   idx;
   logic [0:N-1]    shadow;
   logic            do_clear, do_load, do_start, do_eval, do_commit;
   logic            last_cell;
   logic [3:0]      nbr_cnt;
   logic            next_bit;
   int              r0, c0, rr, cc;
   logic [IW-1:0]   nidx;

   assign last_cell = (idx == IW'(N - 1));

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx  = state;
      do_clear  = 1'b0;
      do_load   = 1'b0;
      do_start  = 1'b0;
      do_eval   = 1'b0;
      do_commit = 1'b0;
      case (state)
         IDLE: begin
            if (clear)                     do_clear = 1'b1;
            else if (load)                 do_load  = 1'b1;
            else if (step || (run && tick)) begin
               do_start = 1'b1;
               state_nx = COMPUTE;
            end
         end
         COMPUTE: begin
            if (clear) begin
               do_clear = 1'b1;
               state_nx = IDLE;
            end else begin
               do_eval = 1'b1;
               if (last_cell) state_nx = COMMIT;
            end
         end
         COMMIT: begin
            if (clear) begin
               do_clear = 1'b1;
            end else begin
               do_commit = 1'b1;
            end
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // Neighbour count for the cell under evaluation, read from the stable cells register.
   always_comb begin
      nbr_cnt = 4'd0;
      r0      = int'(idx) / COLS;
      c0      = int'(idx) % COLS;
      rr      = 0;
      cc      = 0;
      nidx    = '0;
      for (int dr = -1; dr <= 1; dr++) begin
         for (int dc = -1; dc <= 1; dc++) begin
            if (!(dr == 0 && dc == 0)) begin
`ifdef GOL_WRAP_EN
               rr      = (r0 + dr + ROWS) % ROWS;
               cc      = (c0 + dc + COLS) % COLS;
               nidx    = IW'(rr * COLS + cc);
               nbr_cnt = nbr_cnt + {3'b000, cells[nidx]};
`else
               rr = r0 + dr;
               cc = c0 + dc;
               if (rr >= 0 && rr < ROWS && cc >= 0 && cc < COLS) begin
                  nidx    = IW'(rr * COLS + cc);
                  nbr_cnt = nbr_cnt + {3'b000, cells[nidx]};
               end
`endif
            end
         end
      end
      next_bit = (nbr_cnt == 4'd3) || (cells[idx] && nbr_cnt == 4'd2);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cells     <= '0;
         shadow    <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         gen_count <= '0;
         idx       <= '0;
      end else begin
         done <= 1'b0;
         if (do_clear) begin
            cells     <= '0;
            gen_count <= '0;
            busy      <= 1'b0;
         end
         if (do_load) cells <= seed;
         if (do_start) begin
            idx  <= '0;
            busy <= 1'b1;
         end
         if (do_eval) begin
            shadow[idx] <= next_bit;
            idx         <= idx + 1'b1;
            // done is registered so it lines up with the COMMIT cycle
            if (last_cell) done <= 1'b1;
         end
         if (do_commit) begin
            cells     <= shadow;
            gen_count <= gen_count + 1'b1;
            busy      <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_gol_gen_ctrl.sv
// Self-checking bench for gol_gen_ctrl against a whole-grid Life reference model.
module tb_gol_gen_ctrl;
   localparam int COLS  = 64;
   localparam int ROWS  = 48;
   localparam int N     = COLS * ROWS;
   localparam int GEN_W = 16;
   localparam int LAT   = N;

   logic             clk = 1'b0;
   logic             reset, run, tick, step, clear, load;
   logic [0:N-1]     seed;
   logic [0:N-1]     cells;
   logic             busy, done;
   logic [GEN_W-1:0] gen_count;

   int checks   = 0;
   int failures = 0;
   int exp_gen  = 0;

   always #5 clk = ~clk;

   gol_gen_ctrl #(.COLS(COLS), .ROWS(ROWS), .GEN_W(GEN_W)) dut (
      .clk(clk), .reset(reset), .run(run), .tick(tick), .step(step),
      .clear(clear), .load(load), .seed(seed), .cells(cells),
      .busy(busy), .done(done), .gen_count(gen_count)
   );

   function automatic logic [0:N-1] life(input logic [0:N-1] g);
      logic [0:N-1] res;
      int n, y, x;
      res = '0;
      for (int r = 0; r < ROWS; r++) begin
         for (int c = 0; c < COLS; c++) begin
            n = 0;
            for (int dy = -1; dy <= 1; dy++) begin
               for (int dx = -1; dx <= 1; dx++) begin
                  if (dy != 0 || dx != 0) begin
                     y = r + dy;
                     x = c + dx;
`ifdef GOL_WRAP_EN
                     y = (y + ROWS) % ROWS;
                     x = (x + COLS) % COLS;
                     n += int'(g[y*COLS+x]);
`else
                     if (y >= 0 && y < ROWS && x >= 0 && x < COLS) n += int'(g[y*COLS+x]);
`endif
                  end
               end
            end
            res[r*COLS+c] = (n == 3) || (g[r*COLS+c] && n == 2);
         end
      end
      return res;
   endfunction

   function automatic logic [0:N-1] mark(input logic [0:N-1] g, input int r, input int c);
      g[r*COLS+c] = 1'b1;
      return g;
   endfunction

   function automatic logic [0:N-1] rand_grid();
      logic [0:N-1] g;
      for (int i = 0; i < N; i++) g[i] = ($urandom_range(2) == 0);
      return g;
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_done(output int lat);
      lat = -1;
      for (int i = 1; i <= 4000; i++) begin
         cyc();
         if (done) begin
            lat = i;
            break;
         end
      end
   endtask

   task automatic load_grid(input logic [0:N-1] g);
      seed = g;
      load = 1'b1;
      cyc();
      load = 1'b0;
   endtask

   task automatic pulse_step();
      step = 1'b1;
      cyc();
      step = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      cyc();
      cyc();
      reset = 1'b0;
      exp_gen = 0;
      checks++;
      if (cells !== '0 || busy !== 1'b0 || done !== 1'b0 || gen_count !== '0) begin
         failures++;
         $display("FAIL reset: ones=%0d busy=%b done=%b gen=%0d, required 0/0/0/0",
                  $countones(cells), busy, done, gen_count);
      end
   endtask

   task automatic test_blinker();
      logic [0:N-1] h, v;
      int lat;
      h = '0; v = '0;
      for (int c = 20; c <= 22; c++) h = mark(h, 10, c);
      for (int r = 9; r <= 11; r++) v = mark(v, r, 21);
      load_grid(h);
      checks++;
      if (cells !== h) begin
         failures++;
         $display("FAIL load: ones=%0d, required %0d", $countones(cells), $countones(h));
      end
      for (int g = 0; g < 2; g++) begin
         pulse_step();
         checks++;
         if (busy !== 1'b1) begin
            failures++;
            $display("FAIL blinker_busy_start: busy=%b, required 1", busy);
         end
         wait_done(lat);
         checks++;
         if (lat != LAT) begin
            failures++;
            $display("FAIL blinker_latency: done after %0d cycles, required %0d", lat, LAT);
         end
         checks++;
         if (cells !== (g == 0 ? h : v) || busy !== 1'b1) begin
            failures++;
            $display("FAIL blinker_hold: cells changed or busy=%b during COMMIT cycle", busy);
         end
         cyc();
         exp_gen++;
         checks++;
         if (cells !== (g == 0 ? v : h) || cells !== life(g == 0 ? h : v)) begin
            failures++;
            $display("FAIL blinker_gen%0d: ones=%0d, required pattern with 3 cells", g + 1, $countones(cells));
         end
         checks++;
         if (done !== 1'b0 || busy !== 1'b0 || gen_count !== GEN_W'(exp_gen)) begin
            failures++;
            $display("FAIL blinker_status: done=%b busy=%b gen=%0d, required 0 0 %0d", done, busy, gen_count, exp_gen);
         end
      end
   endtask

   task automatic test_still_life();
      logic [0:N-1] b;
      int dones;
      b = '0;
      b = mark(b, 5, 5); b = mark(b, 5, 6); b = mark(b, 6, 5); b = mark(b, 6, 6);
      clear = 1'b1;
      cyc();
      clear = 1'b0;
      exp_gen = 0;
      load_grid(b);
      run = 1'b1;
      dones = 0;
      for (int k = 0; k < 3; k++) begin
         tick = 1'b1;
         cyc();
         tick = 1'b0;
         for (int i = 0; i < 4000; i++) begin
            cyc();
            if (done) dones++;
         end
         exp_gen++;
         checks++;
         if (cells !== b || gen_count !== GEN_W'(exp_gen)) begin
            failures++;
            $display("FAIL still_life_%0d: ones=%0d gen=%0d, required 4 %0d", k, $countones(cells), gen_count, exp_gen);
         end
      end
      run = 1'b0;
      checks++;
      if (dones != 3) begin
         failures++;
         $display("FAIL still_life_dones: %0d done pulses, required 3", dones);
      end
   endtask

   task automatic test_edge();
      logic [0:N-1] s, e;
      int lat;
      s = '0; e = '0;
      for (int r = 0; r <= 2; r++) s = mark(s, r, 63);
      e = mark(e, 1, 62);
      e = mark(e, 1, 63);
`ifdef GOL_WRAP_EN
      e = mark(e, 1, 0);
`endif
      load_grid(s);
      pulse_step();
      wait_done(lat);
      cyc();
      exp_gen++;
      checks++;
      if (lat != LAT || cells !== e || cells !== life(s)) begin
         failures++;
         $display("FAIL edge: lat=%0d ones=%0d col0=%b, required lat=%0d ones=%0d",
                  lat, $countones(cells), cells[1*COLS+0], LAT, $countones(e));
      end
   endtask

   task automatic test_abort();
      int dones, busy_hi;
      load_grid(rand_grid());
      pulse_step();
      for (int i = 0; i < 999; i++) cyc();
      clear = 1'b1;
      cyc();
      clear = 1'b0;
      exp_gen = 0;
      checks++;
      if (cells !== '0 || busy !== 1'b0 || gen_count !== '0) begin
         failures++;
         $display("FAIL abort: ones=%0d busy=%b gen=%0d, required 0 0 0", $countones(cells), busy, gen_count);
      end
      dones = 0; busy_hi = 0;
      for (int i = 0; i < 4000; i++) begin
         cyc();
         if (done) dones++;
         if (busy) busy_hi++;
      end
      checks++;
      if (dones != 0 || busy_hi != 0) begin
         failures++;
         $display("FAIL abort_quiet: dones=%0d busy_cycles=%0d, required 0 0", dones, busy_hi);
      end
   endtask

   task automatic test_ignored();
      logic [0:N-1] s0, ones;
      int dones, falls, ones_seen;
      logic prev_busy;
      ones = '1;
      s0 = rand_grid();
      load_grid(s0);
      pulse_step();
      prev_busy = busy;
      dones = 0; falls = 0; ones_seen = 0;
      for (int i = 0; i < 7000; i++) begin
         if (i == 50) begin run = 1'b1; tick = 1'b1; end
         if (i == 51) begin tick = 1'b0; step = 1'b1; end
         if (i == 52) begin step = 1'b0; seed = ones; load = 1'b1; end
         if (i == 53) begin load = 1'b0; run = 1'b0; end
         cyc();
         if (cells === ones) ones_seen++;
         if (prev_busy && !busy) falls++;
         if (done) dones++;
         prev_busy = busy;
      end
      exp_gen++;
      checks++;
      if (cells !== life(s0) || gen_count !== GEN_W'(exp_gen)) begin
         failures++;
         $display("FAIL ignored_result: ones=%0d gen=%0d, required ones=%0d gen=%0d",
                  $countones(cells), gen_count, $countones(life(s0)), exp_gen);
      end
      checks++;
      if (dones != 1 || falls != 1 || ones_seen != 0) begin
         failures++;
         $display("FAIL ignored_cmds: dones=%0d busy_falls=%0d all_ones_seen=%0d, required 1 1 0", dones, falls, ones_seen);
      end
   endtask

   task automatic test_priority();
      int busy_hi;
      load_grid(rand_grid());
      seed = rand_grid();
      clear = 1'b1; load = 1'b1; step = 1'b1;
      cyc();
      clear = 1'b0; load = 1'b0; step = 1'b0;
      exp_gen = 0;
      busy_hi = 0;
      for (int i = 0; i < 5; i++) begin
         if (busy) busy_hi++;
         cyc();
      end
      checks++;
      if (cells !== '0 || gen_count !== '0 || busy_hi != 0) begin
         failures++;
         $display("FAIL priority: ones=%0d gen=%0d busy_cycles=%0d, required 0 0 0", $countones(cells), gen_count, busy_hi);
      end
   endtask

   task automatic test_random();
      logic [0:N-1] cur;
      int lat;
      cur = cells;
      for (int k = 0; k < 4; k++) begin
         if ($urandom_range(1) == 1) begin
            cur = rand_grid();
            load_grid(cur);
         end
         for (int w = $urandom_range(3); w > 0; w--) cyc();
         if ($urandom_range(1) == 1) begin
            pulse_step();
         end else begin
            run = 1'b1; tick = 1'b1;
            cyc();
            tick = 1'b0; run = 1'b0;
         end
         wait_done(lat);
         cyc();
         cur = life(cur);
         exp_gen++;
         checks++;
         if (lat != LAT || cells !== cur || gen_count !== GEN_W'(exp_gen)) begin
            failures++;
            $display("FAIL random_%0d: lat=%0d ones=%0d gen=%0d, required lat=%0d ones=%0d gen=%0d",
                     k, lat, $countones(cells), gen_count, LAT, $countones(cur), exp_gen);
         end
      end
   endtask

   task automatic test_reset_mid();
      int busy_hi;
      load_grid(rand_grid());
      pulse_step();
      for (int i = 0; i < 500; i++) cyc();
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      exp_gen = 0;
      busy_hi = 0;
      checks++;
      if (cells !== '0 || busy !== 1'b0 || done !== 1'b0 || gen_count !== '0) begin
         failures++;
         $display("FAIL reset_mid: ones=%0d busy=%b done=%b gen=%0d, required all 0", $countones(cells), busy, done, gen_count);
      end
      for (int i = 0; i < 3200; i++) begin
         cyc();
         if (busy || done) busy_hi++;
      end
      checks++;
      if (busy_hi != 0) begin
         failures++;
         $display("FAIL reset_mid_quiet: %0d busy/done cycles, required 0", busy_hi);
      end
   endtask

   initial begin
      reset = 1'b1; run = 1'b0; tick = 1'b0; step = 1'b0;
      clear = 1'b0; load = 1'b0; seed = '0;
      test_reset();
      test_blinker();
      test_still_life();
      test_edge();
      test_abort();
      test_ignored();
      test_priority();
      test_random();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/gol_gen_ctrl.md
Name: gol_gen_ctrl

Overview:
- Owns the 64x48 Game of Life cell state and sequences generation updates using Conway B3/S23 rules.
- Evaluates one cell per clock into a shadow buffer, then commits the whole grid in one cycle, so the display sees only complete generations.
- Sits between the user-control logic (buttons, frame-tick divider) and the pixel renderer, which consumes the `cells` vector.

Parameters:
- COLS, 64, grid width in cells
- ROWS, 48, grid height in cells
- GEN_W, 16, width of the generation counter

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- run  input  1  level; 1 = free-running, advance one generation on each tick
- tick  input  1  one-cycle pulse from the frame/rate divider
- step  input  1  one-cycle pulse; advance exactly one generation, regardless of run
- clear  input  1  one-cycle pulse; kill all cells
- load  input  1  one-cycle pulse; copy seed into the grid
- seed  input  COLS*ROWS  initial pattern, indexed [0:COLS*ROWS-1]
- cells  output  COLS*ROWS  current grid, indexed [0:COLS*ROWS-1]; index = row*COLS+col; bit 0 = top-left cell; 1 = alive
- busy  output  1  high while a generation is being computed
- done  output  1  one-cycle pulse on generation commit
- gen_count  output  GEN_W  number of generations committed since the last reset or clear

Behaviour:
- Interface: one clock, `clk`; `reset` is synchronous and active-high.
- Reset values: cells=0, shadow buffer=0, busy=0, done=0, gen_count=0, idx=0, state=IDLE.
- States: IDLE, COMPUTE, COMMIT.
- IDLE, command priority (highest first): clear > load > step > (run && tick).
  - clear: cells<=0, gen_count<=0; stay in IDLE.
  - load: cells<=seed; gen_count unchanged; stay in IDLE.
  - step, or run && tick: idx<=0, busy<=1, go to COMPUTE.
- COMPUTE:
  - Each cycle, for cell idx (row=idx/COLS, col=idx%COLS), count the 8 live neighbours from `cells` (4-bit count, 0..8).
  - next[idx] = (count==3) | (cells[idx] & count==2).
  - idx increments by 1 each cycle. After writing idx = COLS*ROWS-1, go to COMMIT.
  - `cells` is held constant throughout COMPUTE.
- COMMIT:
  - cells<=next, gen_count<=gen_count+1 (wraps modulo 2^GEN_W).
  - done=1 for this cycle only, busy<=0, go to IDLE.
- Latency: a start command sampled at edge T gives COMPUTE on cycles T+1..T+3072 and COMMIT on T+3073. The new `cells` value is visible after edge T+3073. busy is high from T+1 through the COMMIT cycle.
- While busy:
  - tick, step and load are ignored; they are not queued.
  - clear aborts: on the next edge cells<=0, gen_count<=0, busy<=0, state=IDLE, no done pulse.
- reset mid-COMPUTE returns everything to the reset values on the next edge.
- Outputs are registered. `cells` changes only on load, clear, COMMIT or reset.
- An all-dead grid still runs the full 3072-cycle scan and increments gen_count.

Optional Feature:
- Macro: GOL_WRAP_EN.
- Defined: toroidal grid. Neighbour row/col wrap modulo ROWS/COLS, so col 0 neighbours col COLS-1 and row 0 neighbours row ROWS-1.
- Undefined: dead border. Any neighbour coordinate outside 0..COLS-1 / 0..ROWS-1 counts as dead.

Test Plan:
- Blinker: reset; load seed with row 10, cols 20-22 alive; pulse step. Expected: after 3073 cycles done=1, cells has col 21, rows 9-11 alive, gen_count=1. A second step restores the original pattern, gen_count=2.
- Still life: load a 2x2 block at rows 5-6, cols 5-6; run=1 with 3 ticks spaced 4000 cycles apart. Expected: cells unchanged after each commit, gen_count=3, exactly 3 done pulses.
- Edge behaviour: load a vertical blinker at col 63, rows 0-2; step.
  - With GOL_WRAP_EN: row 1, cols 62, 63 and 0 alive.
  - Without GOL_WRAP_EN: row 1, cols 62-63 alive, col 0 dead.
- Abort: start a step, pulse clear at cycle 1000 of COMPUTE. Expected: next cycle cells=0, busy=0, gen_count=0, and no done pulse for 4000 cycles.
- Ignored commands: during COMPUTE pulse tick, step and load (seed all-ones). Expected: one generation only; cells never equals all-ones; busy falls exactly once.
- Priority: in IDLE assert clear, load and step in the same cycle. Expected: cells=0, gen_count=0, busy stays 0.
